// File: rtl/synaptic_dispatch_scheduler_if.sv
// rtl/synaptic_dispatch_scheduler_if.sv - bus bundle between the synaptic dispatch scheduler and its neighbours
// Ports (master = neuron update stage / SPU side, slave = scheduler):
//   step_start, fire_phase_done       timestep control
//   push_valid, push_tag, full        fired-tag push channel
//   fifo_empty, spu_req_deq,
//   deq_grant, src_tag_out            SPU dequeue channel
//   spu_req_write, wr_grant           shared i_next write port arbitration
//   spu_busy, step_done, overflow     completion and status
interface synaptic_dispatch_scheduler_if #(
  parameter int numspu  = 2,
  parameter int tagbits = 1
);
  logic               step_start;
  logic               fire_phase_done;
  logic               push_valid;
  logic [tagbits-1:0] push_tag;
  logic               full;
  logic               fifo_empty;
  logic [numspu-1:0]  spu_req_deq;
  logic [numspu-1:0]  deq_grant;
  logic [tagbits-1:0] src_tag_out;
  logic [numspu-1:0]  spu_req_write;
  logic [numspu-1:0]  wr_grant;
  logic [numspu-1:0]  spu_busy;
  logic               step_done;
  logic               overflow;

  modport master (
    output step_start, fire_phase_done, push_valid, push_tag,
    output spu_req_deq, spu_req_write, spu_busy,
    input  full, fifo_empty, deq_grant, src_tag_out, wr_grant, step_done, overflow
  );

  modport slave (
    input  step_start, fire_phase_done, push_valid, push_tag,
    input  spu_req_deq, spu_req_write, spu_busy,
    output full, fifo_empty, deq_grant, src_tag_out, wr_grant, step_done, overflow
  );
endinterface

// File: rtl/synaptic_dispatch_scheduler.sv
// rtl/synaptic_dispatch_scheduler.sv - synaptic phase sequencer, fired-tag FIFO and round-robin SPU arbiters
// Ports:
//   clk         rising-edge clock
//   asyn_reset  asynchronous active-high reset
//   bus         synaptic_dispatch_scheduler_if.slave (push channel, dequeue
//               and write arbitration, busy/done/overflow status)
module synaptic_dispatch_scheduler #(
  parameter int numspu       = 2,
  parameter int tagbits      = 1,
  parameter int fifoaddrbits = 2
) (
  input logic                          clk,
  input logic                          asyn_reset,
  synaptic_dispatch_scheduler_if.slave bus
);

  localparam int depth   = 1 << fifoaddrbits;
  localparam int ptrbits = (numspu > 1) ? $clog2(numspu) : 1;
  localparam logic [fifoaddrbits:0] depth_cnt = (fifoaddrbits + 1)'(depth);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_FIRE  = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t state, state_nxt;

  logic [tagbits-1:0]      mem [depth];
  logic [fifoaddrbits-1:0] head, tail;
  logic [fifoaddrbits:0]   count;
  logic [ptrbits-1:0]      deq_ptr, wr_ptr;
  logic                    overflow_q;

  logic                    fifo_full, fifo_empty;
  logic [numspu-1:0]       deq_g, wr_g;
  logic                    push_ok, pop, drop;
  logic                    clr_ovf, step_done_c;

  // Round-robin pick: lowest requester at or above ptr wins, otherwise the
  // search wraps to the lowest requester overall.
  function automatic logic [numspu-1:0] rr_grant(input logic [numspu-1:0] req,
                                                 input logic [ptrbits-1:0] ptr);
    logic [numspu-1:0] g;
    logic              found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < numspu; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    for (int i = 0; i < numspu; i++) begin
      if (!found && req[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Pointer that follows a one-hot grant: granted index + 1, wrapping.
  function automatic logic [ptrbits-1:0] next_ptr(input logic [numspu-1:0] g);
    logic [ptrbits-1:0] p;
    p = '0;
    for (int i = 0; i < numspu; i++) begin
      if (g[i]) p = (i == numspu - 1) ? '0 : ptrbits'(i + 1);
    end
    return p;
  endfunction

  assign fifo_full  = (count == depth_cnt);
  assign fifo_empty = (count == '0);

  // No push-to-pop bypass: a pop needs an entry already present this cycle.
  assign deq_g = fifo_empty ? '0 : rr_grant(bus.spu_req_deq, deq_ptr);
  assign wr_g  = rr_grant(bus.spu_req_write, wr_ptr);

  assign push_ok = (state == S_FIRE) && bus.push_valid && !fifo_full;
  assign drop    = bus.push_valid && !push_ok;
  assign pop     = |deq_g;

  assign bus.full        = fifo_full;
  assign bus.fifo_empty  = fifo_empty;
  assign bus.deq_grant   = deq_g;
  assign bus.wr_grant    = wr_g;
  assign bus.src_tag_out = mem[head];
  assign bus.step_done   = step_done_c;
  assign bus.overflow    = overflow_q;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    step_done_c = 1'b0;
    clr_ovf     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.step_start) begin
          state_nxt = S_FIRE;
          clr_ovf   = 1'b1;
        end
      end
      S_FIRE: begin
        if (bus.fire_phase_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && (bus.spu_busy == '0) && (bus.spu_req_deq == '0) &&
            (bus.spu_req_write == '0)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        step_done_c = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage is reset too so src_tag_out reads 0 straight out of reset.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      deq_ptr    <= '0;
      wr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[tail] <= bus.push_tag;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head    <= head + 1'b1;
        deq_ptr <= next_ptr(deq_g);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (|wr_g) wr_ptr <= next_ptr(wr_g);
      // A new step starts with a clean flag even if a stray push lands with step_start.
      if (clr_ovf) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synaptic_dispatch_scheduler.sv
// tb/tb_synaptic_dispatch_scheduler.sv - self-checking bench for synaptic_dispatch_scheduler
module tb_synaptic_dispatch_scheduler;
  localparam int NS    = 2;
  localparam int TB    = 1;
  localparam int FA    = 2;
  localparam int DEPTH = 1 << FA;

  localparam int P_IDLE  = 0;
  localparam int P_FIRE  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic asyn_reset;
  always #5 clk = ~clk;

  synaptic_dispatch_scheduler_if #(.numspu(NS), .tagbits(TB)) bus ();

  synaptic_dispatch_scheduler #(.numspu(NS), .tagbits(TB), .fifoaddrbits(FA)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [TB-1:0] q[$];
  int            phase;
  int            mdp, mwp;
  bit            movf;

  // values seen in the most recent tick, for directed checks
  logic [NS-1:0] obs_deq, obs_wr;
  logic [TB-1:0] obs_tag;
  logic          obs_full, obs_empty, obs_done, obs_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int req, input int ptr);
    for (int k = 0; k < NS; k++) begin
      int j;
      j = (ptr + k) % NS;
      if (((req >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  function automatic int onehot(input int idx);
    return (idx < 0) ? 0 : (1 << idx);
  endfunction

  task automatic set_in(input bit ss, input bit fpd, input bit pv, input logic [TB-1:0] pt,
                        input logic [NS-1:0] rd, input logic [NS-1:0] rw, input logic [NS-1:0] busy);
    bus.step_start      = ss;
    bus.fire_phase_done = fpd;
    bus.push_valid      = pv;
    bus.push_tag        = pt;
    bus.spu_req_deq     = rd;
    bus.spu_req_write   = rw;
    bus.spu_busy        = busy;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    asyn_reset = 1'b1;
    #1;
    chk("rst_full",      32'(bus.full),        32'd0);
    chk("rst_empty",     32'(bus.fifo_empty),  32'd1);
    chk("rst_deq_grant", 32'(bus.deq_grant),   32'd0);
    chk("rst_wr_grant",  32'(bus.wr_grant),    32'd0);
    chk("rst_src_tag",   32'(bus.src_tag_out), 32'd0);
    chk("rst_step_done", 32'(bus.step_done),   32'd0);
    chk("rst_overflow",  32'(bus.overflow),    32'd0);
    q.delete();
    phase = P_IDLE;
    mdp   = 0;
    mwp   = 0;
    movf  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    asyn_reset = 1'b0;
  endtask

  // One clock: compare outputs against the model with inputs settled, then
  // advance the model across the edge using the same inputs.
  task automatic tick();
    int sz, d, w, rd, rw, busy;
    bit ss, fpd, pv;
    logic [TB-1:0] pt;
    #1;
    sz   = q.size();
    rd   = int'(bus.spu_req_deq);
    rw   = int'(bus.spu_req_write);
    busy = int'(bus.spu_busy);
    ss   = bus.step_start;
    fpd  = bus.fire_phase_done;
    pv   = bus.push_valid;
    pt   = bus.push_tag;
    d    = (sz == 0) ? -1 : rr_pick(rd, mdp);
    w    = rr_pick(rw, mwp);
    obs_deq   = bus.deq_grant;
    obs_wr    = bus.wr_grant;
    obs_tag   = bus.src_tag_out;
    obs_full  = bus.full;
    obs_empty = bus.fifo_empty;
    obs_done  = bus.step_done;
    obs_ovf   = bus.overflow;
    chk("full",      32'(obs_full),  32'(sz == DEPTH));
    chk("fifo_empty", 32'(obs_empty), 32'(sz == 0));
    chk("deq_grant", 32'(obs_deq),   32'(onehot(d)));
    chk("wr_grant",  32'(obs_wr),    32'(onehot(w)));
    chk("step_done", 32'(obs_done),  32'(phase == P_DONE));
    chk("overflow",  32'(obs_ovf),   32'(movf));
    if (sz != 0) chk("src_tag_out", 32'(obs_tag), 32'(q[0]));
    @(posedge clk);
    if (d >= 0) begin
      void'(q.pop_front());
      mdp = (d + 1) % NS;
    end
    if (w >= 0) mwp = (w + 1) % NS;
    if (pv) begin
      if (phase == P_FIRE && sz < DEPTH) q.push_back(pt);
      else movf = 1'b1;
    end
    case (phase)
      P_IDLE:  if (ss) begin phase = P_FIRE; movf = 1'b0; end
      P_FIRE:  if (fpd) phase = P_DRAIN;
      P_DRAIN: if (sz == 0 && busy == 0 && rd == 0 && rw == 0) phase = P_DONE;
      default: phase = P_IDLE;
    endcase
    @(negedge clk);
  endtask

  logic [TB-1:0] t3_tags [4];
  logic [NS-1:0] prd, prw, rbusy;

  initial begin
    asyn_reset = 1'b1;
    do_reset();

    // basic step: push 1 then 0, drain through SPU0, completion pulse
    set_in(1, 0, 0, 0, 0, 0, 0);           tick();
    set_in(0, 0, 1, 1, 0, 0, 2'b01);       tick();
    set_in(0, 0, 1, 0, 0, 0, 2'b01);       tick();
    set_in(0, 1, 0, 0, 0, 0, 2'b01);       tick();
    set_in(0, 0, 0, 0, 2'b01, 0, 2'b01);   tick();
    chk("t1_grant0", 32'(obs_deq), 32'h1);
    chk("t1_tag0",   32'(obs_tag), 32'h1);
    tick();
    chk("t1_grant1", 32'(obs_deq), 32'h1);
    chk("t1_tag1",   32'(obs_tag), 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 2'b01);       tick();
    chk("t1_empty", 32'(obs_empty), 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0);           tick();
    chk("t1_done_early", 32'(obs_done), 32'h0);
    tick();
    chk("t1_done", 32'(obs_done), 32'h1);
    tick();
    chk("t1_done_once", 32'(obs_done), 32'h0);

    // overflow on a full FIFO, then round-robin dequeue of the four entries
    do_reset();
    t3_tags[0] = 1'b1; t3_tags[1] = 1'b0; t3_tags[2] = 1'b1; t3_tags[3] = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, t3_tags[k], 0, 0, 0); tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0); tick();
    chk("t2_full", 32'(obs_full), 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t2_overflow", 32'(obs_ovf), 32'h1);
    set_in(0, 0, 0, 0, 2'b11, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_grant", 32'(obs_deq), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_tag",   32'(obs_tag), 32'(t3_tags[k]));
    end
    set_in(0, 1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    tick();
    chk("t2_ovf_sticky", 32'(obs_ovf), 32'h1);
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t2_ovf_clear", 32'(obs_ovf), 32'h0);

    // write-port arbitration
    set_in(0, 0, 0, 0, 0, 2'b11, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_wr_both", 32'(obs_wr), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    set_in(0, 0, 0, 0, 0, 2'b10, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_wr_one", 32'(obs_wr), 32'h2);
    end

    // simultaneous push/pop at count=1, and no bypass into an empty FIFO
    set_in(0, 0, 1, 1, 0, 0, 0);     tick();
    set_in(0, 0, 1, 0, 2'b01, 0, 0); tick();
    chk("t5_pp_grant", 32'(obs_deq), 32'h1);
    chk("t5_pp_tag",   32'(obs_tag), 32'h1);
    set_in(0, 0, 0, 0, 0, 0, 0);     tick();
    chk("t5_head", 32'(obs_tag), 32'h0);
    chk("t5_nonempty", 32'(obs_empty), 32'h0);
    set_in(0, 0, 0, 0, 2'b01, 0, 0); tick();
    set_in(0, 0, 1, 1, 2'b01, 0, 0); tick();
    chk("t5_no_bypass", 32'(obs_deq), 32'h0);
    set_in(0, 0, 0, 0, 2'b01, 0, 0); tick();
    chk("t5_late_grant", 32'(obs_deq), 32'h1);
    chk("t5_late_tag",   32'(obs_tag), 32'h1);

    // reset in the middle of the drain phase with two tags queued
    set_in(0, 0, 1, 0, 0, 0, 0);     tick();
    set_in(0, 0, 1, 1, 0, 0, 0);     tick();
    set_in(0, 1, 0, 0, 0, 0, 0);     tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b01); tick();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_done", 32'(obs_done), 32'h0);
    end

    // randomized traffic against the model
    prd = '0;
    prw = '0;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        do_reset();
        prd = '0;
        prw = '0;
      end
      if ($urandom_range(0, 3) == 0) prd = prd | NS'($urandom);
      if ($urandom_range(0, 3) == 0) prw = prw | NS'($urandom);
      rbusy = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 1) == 1, TB'($urandom), prd, prw, rbusy);
      tick();
      prd = prd & ~obs_deq;
      prw = prw & ~obs_wr;
      if (q.size() == 0) prd = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
